// File: rtl/el2_pkg.sv
// Shared fetch-buffer types and constants for the IFU.
// Depth matches the 4-slot fullness model used by fetch control's throttling.
package el2_pkg;

    localparam int EL2_FB_DEPTH  = 4;
    localparam int EL2_FB_DATA_W = 32;

    typedef struct packed {
        logic [1:0]               val;
        logic [31:1]              pc;
        logic [EL2_FB_DATA_W-1:0] data;
        logic                     err;
    } el2_fb_pkt_t;

    // A fetch that starts on the upper halfword carries no valid lower halfword.
    function automatic logic [1:0] fb_hw_val(input logic addr1);
        return addr1 ? 2'b10 : 2'b11;
    endfunction

endpackage

// File: rtl/rvdffe.sv
// Enabled register with synchronous active-low reset.
// Latency 1 cycle from i_en to o_dout; no flow control.
// No backpressure; holds its value whenever i_en is low.
module rvdffe #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_l,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_l) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_din;
        end
    end

    assign o_dout = r_q;

endmodule

// File: rtl/el2_ifu_fetch_buf.sv
// IFU fetch buffer: queues hit fetch packets and presents the two oldest to the aligner.
// Latency 1 cycle write-to-f0; with EL2_FB_BYPASS_EN an empty buffer forwards the packet same cycle.
// No backpressure port: fetch control throttles; a write into a full buffer without a pop is dropped and sets fb_overflow.
module el2_ifu_fetch_buf
    import el2_pkg::*;
#(
    parameter int DEPTH  = EL2_FB_DEPTH,
    parameter int DATA_W = EL2_FB_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              ifc_fetch_req_f,
    input  logic              ic_hit_f,
    input  logic [31:1]       ifc_fetch_addr_f,
    input  logic [DATA_W-1:0] ic_data_f,
    input  logic              ic_access_fault_f,
    input  logic              exu_flush_final,
    input  logic              ifu_fb_consume1,
    input  logic              ifu_fb_consume2,
    output logic [1:0]        f0_val,
    output logic [31:1]       f0_pc,
    output logic [DATA_W-1:0] f0_data,
    output logic              f0_err,
    output logic [1:0]        f1_val,
    output logic [31:1]       f1_pc,
    output logic [DATA_W-1:0] f1_data,
    output logic              f1_err,
    output logic [PTR_W:0]    fb_count,
    output logic              fb_overflow
);

    localparam int            PKT_W   = 2 + 31 + DATA_W + 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;

    logic             w_wr;
    logic             w_empty;
    logic             w_full;
    logic             w_byp;
    logic             w_byp_take;
    logic             w_drop;
    logic             w_wr_acc;
    logic [PTR_W:0]   w_pop_req;
    logic [PTR_W:0]   w_pop_eff;
    logic [PTR_W-1:0] w_rd_ptr1;
    logic [PKT_W-1:0] w_wr_pkt;
    logic [PKT_W-1:0] w_ent [DEPTH];
    logic [PKT_W-1:0] w_f0;
    logic [PKT_W-1:0] w_f1;
    logic [1:0]       w_f0_val_raw;
    logic [1:0]       w_f1_val_raw;

    assign w_wr      = ifc_fetch_req_f & ic_hit_f & ~exu_flush_final;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_pop_req = ifu_fb_consume2 ? (PTR_W+1)'(2) :
                       ifu_fb_consume1 ? (PTR_W+1)'(1) : '0;
    assign w_pop_eff = (w_pop_req > r_count) ? r_count : w_pop_req;

`ifdef EL2_FB_BYPASS_EN
    assign w_byp      = w_empty & w_wr;
    assign w_byp_take = w_byp & (ifu_fb_consume1 | ifu_fb_consume2);
`else
    assign w_byp      = 1'b0;
    assign w_byp_take = 1'b0;
`endif

    // Pop is applied before write, so a full buffer still accepts a write alongside a pop.
    assign w_drop   = w_wr & w_full & (w_pop_eff == '0);
    assign w_wr_acc = w_wr & ~w_drop & ~w_byp_take;
    assign w_wr_pkt = {fb_hw_val(ifc_fetch_addr_f[1]), ifc_fetch_addr_f, ic_data_f, ic_access_fault_f};

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (exu_flush_final) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + w_pop_eff[PTR_W-1:0];
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_wr_acc);
            r_count  <= r_count - w_pop_eff + (PTR_W+1)'(w_wr_acc);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        rvdffe #(.WIDTH(PKT_W)) u_ent (
            .i_clk   (clk),
            .i_rst_l (rst_l),
            .i_en    (w_wr_acc & (r_wr_ptr == PTR_W'(i))),
            .i_din   (w_wr_pkt),
            .o_dout  (w_ent[i])
        );
    end

    assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);
    assign w_f0      = w_byp ? w_wr_pkt : w_ent[r_rd_ptr];
    assign w_f1      = w_ent[w_rd_ptr1];

    assign {w_f0_val_raw, f0_pc, f0_data, f0_err} = w_f0;
    assign {w_f1_val_raw, f1_pc, f1_data, f1_err} = w_f1;

    assign f0_val      = (w_empty & ~w_byp) ? 2'b00 : w_f0_val_raw;
    assign f1_val      = (r_count < (PTR_W+1)'(2)) ? 2'b00 : w_f1_val_raw;
    assign fb_count    = r_count;
    assign fb_overflow = r_overflow;

endmodule

// File: tb/tb_el2_ifu_fetch_buf.sv
// Directed, table-driven bench for el2_ifu_fetch_buf with hand-computed expectations.
module tb_el2_ifu_fetch_buf;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        req = 1'b0, hit = 1'b0, flt = 1'b0, flush = 1'b0, c1 = 1'b0, c2 = 1'b0;
    logic [31:1] addr = '0;
    logic [31:0] data = '0;
    logic [1:0]  f0_val, f1_val;
    logic [31:1] f0_pc, f1_pc;
    logic [31:0] f0_data, f1_data;
    logic        f0_err, f1_err;
    logic [2:0]  fb_count;
    logic        fb_overflow;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    el2_ifu_fetch_buf dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .ifc_fetch_req_f   (req),
        .ic_hit_f          (hit),
        .ifc_fetch_addr_f  (addr),
        .ic_data_f         (data),
        .ic_access_fault_f (flt),
        .exu_flush_final   (flush),
        .ifu_fb_consume1   (c1),
        .ifu_fb_consume2   (c2),
        .f0_val            (f0_val),
        .f0_pc             (f0_pc),
        .f0_data           (f0_data),
        .f0_err            (f0_err),
        .f1_val            (f1_val),
        .f1_pc             (f1_pc),
        .f1_data           (f1_data),
        .f1_err            (f1_err),
        .fb_count          (fb_count),
        .fb_overflow       (fb_overflow)
    );

    typedef struct {
        logic        req, hit;
        logic [31:0] pc;
        logic        flt, flush, c1, c2;
        logic [2:0]  e_cnt;
        logic [1:0]  e_f0v;
        logic [31:0] e_f0pc;
        logic        e_f0err;
        logic [1:0]  e_f1v;
        logic [31:0] e_f1pc;
        logic        e_ovf;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] data_fn(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    function automatic vec_t mk(input logic rq, input logic ht, input logic [31:0] pc,
                                input logic fl, input logic fs, input logic k1, input logic k2,
                                input logic [2:0] cnt, input logic [1:0] f0v, input logic [31:0] f0pc,
                                input logic f0e, input logic [1:0] f1v, input logic [31:0] f1pc,
                                input logic ovf);
        vec_t v;
        v.req = rq; v.hit = ht; v.pc = pc; v.flt = fl; v.flush = fs; v.c1 = k1; v.c2 = k2;
        v.e_cnt = cnt; v.e_f0v = f0v; v.e_f0pc = f0pc; v.e_f0err = f0e;
        v.e_f1v = f1v; v.e_f1pc = f1pc; v.e_ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        req = 1'b0; hit = 1'b0; flt = 1'b0; flush = 1'b0; c1 = 1'b0; c2 = 1'b0;
        addr = '0; data = '0;
    endtask

    task automatic drive(input logic rq, input logic ht, input logic [31:0] pc,
                         input logic fl, input logic fs, input logic k1, input logic k2);
        req = rq; hit = ht; addr = pc[31:1]; data = data_fn(pc);
        flt = fl; flush = fs; c1 = k1; c2 = k2;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1 idle();
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.req, v.hit, v.pc, v.flt, v.flush, v.c1, v.c2);
        cycle();
        chk($sformatf("v%0d_count", idx), 64'(fb_count), 64'(v.e_cnt));
        chk($sformatf("v%0d_f0_val", idx), 64'(f0_val), 64'(v.e_f0v));
        chk($sformatf("v%0d_f1_val", idx), 64'(f1_val), 64'(v.e_f1v));
        chk($sformatf("v%0d_overflow", idx), 64'(fb_overflow), 64'(v.e_ovf));
        if (v.e_f0v != 2'b00) begin
            chk($sformatf("v%0d_f0_pc", idx), 64'(f0_pc), 64'(v.e_f0pc[31:1]));
            chk($sformatf("v%0d_f0_data", idx), 64'(f0_data), 64'(data_fn(v.e_f0pc)));
            chk($sformatf("v%0d_f0_err", idx), 64'(f0_err), 64'(v.e_f0err));
        end
        if (v.e_f1v != 2'b00) begin
            chk($sformatf("v%0d_f1_pc", idx), 64'(f1_pc), 64'(v.e_f1pc[31:1]));
            chk($sformatf("v%0d_f1_data", idx), 64'(f1_data), 64'(data_fn(v.e_f1pc)));
        end
    endtask

    initial begin
        //       rq hit pc          flt fs c1 c2  cnt f0v f0pc         e  f1v f1pc         ovf
        vt.push_back(mk(1, 1, 32'h100, 0, 0, 0, 0, 1, 3, 32'h100, 0, 0, 32'h0,   0));
        vt.push_back(mk(1, 1, 32'h104, 0, 0, 0, 0, 2, 3, 32'h100, 0, 3, 32'h104, 0));
        vt.push_back(mk(1, 1, 32'h108, 0, 0, 0, 0, 3, 3, 32'h100, 0, 3, 32'h104, 0));
        vt.push_back(mk(1, 1, 32'h10C, 0, 0, 0, 0, 4, 3, 32'h100, 0, 3, 32'h104, 0));
        vt.push_back(mk(1, 1, 32'h110, 0, 0, 1, 0, 4, 3, 32'h104, 0, 3, 32'h108, 0));
        vt.push_back(mk(1, 1, 32'h114, 0, 0, 0, 0, 4, 3, 32'h104, 0, 3, 32'h108, 1));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, 0, 3, 3, 32'h108, 0, 3, 32'h10C, 1));
        vt.push_back(mk(1, 1, 32'h118, 0, 1, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1));
        vt.push_back(mk(1, 1, 32'h102, 1, 0, 0, 0, 1, 2, 32'h102, 1, 0, 32'h0,   1));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 1, 0, 0, 32'h0,   0, 0, 32'h0,   1));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 1, 0, 0, 32'h0,   0, 0, 32'h0,   1));
        vt.push_back(mk(1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1));
        vt.push_back(mk(1, 1, 32'h120, 0, 0, 0, 0, 1, 3, 32'h120, 0, 0, 32'h0,   1));
        vt.push_back(mk(1, 1, 32'h124, 0, 0, 0, 0, 2, 3, 32'h120, 0, 3, 32'h124, 1));
        vt.push_back(mk(1, 1, 32'h128, 0, 0, 0, 0, 3, 3, 32'h120, 0, 3, 32'h124, 1));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 0, 1, 1, 3, 32'h128, 0, 0, 32'h0,   1));
        vt.push_back(mk(0, 0, 32'h0,   0, 0, 1, 1, 0, 0, 32'h0,   0, 0, 32'h0,   1));

        // Reset state
        idle();
        rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(fb_count), 64'd0);
        chk("rst_f0_val", 64'(f0_val), 64'd0);
        chk("rst_f1_val", 64'(f1_val), 64'd0);
        chk("rst_overflow", 64'(fb_overflow), 64'd0);
        chk("rst_f0_pc", 64'(f0_pc), 64'd0);
        chk("rst_f0_data", 64'(f0_data), 64'd0);
        chk("rst_f0_err", 64'(f0_err), 64'd0);
        rst_l = 1'b1;

        foreach (vt[i]) apply(vt[i], i);

        // Wrap: one packet in flight, then ten write+consume1 pairs carry rd_ptr around the ring.
        drive(1, 1, 32'h300, 0, 0, 0, 0);
        cycle();
        chk("wrap_seed_pc", 64'(f0_pc), 64'(32'h180));
        for (int k = 1; k <= 10; k++) begin
            drive(1, 1, 32'h300 + 32'(4 * k), 0, 0, 1, 0);
            cycle();
            chk($sformatf("wrap%0d_count", k), 64'(fb_count), 64'd1);
            chk($sformatf("wrap%0d_f0_pc", k), 64'(f0_pc), 64'((32'h300 + 32'(4 * k)) >> 1));
            chk($sformatf("wrap%0d_f0_data", k), 64'(f0_data), 64'(data_fn(32'h300 + 32'(4 * k))));
        end
        drive(0, 0, 32'h0, 0, 0, 1, 0);
        cycle();
        chk("wrap_drain_count", 64'(fb_count), 64'd0);
        chk("wrap_drain_f0_val", 64'(f0_val), 64'd0);

`ifdef EL2_FB_BYPASS_EN
        drive(1, 1, 32'h400, 0, 0, 1, 0);
        #1;
        chk("byp_f0_val", 64'(f0_val), 64'd3);
        chk("byp_f0_pc", 64'(f0_pc), 64'(32'h200));
        chk("byp_f0_data", 64'(f0_data), 64'(data_fn(32'h400)));
        cycle();
        chk("byp_count", 64'(fb_count), 64'd0);
        chk("byp_f0_val_after", 64'(f0_val), 64'd0);
`endif

        // Mid-operation reset drops contents and clears the sticky overflow flag.
        drive(1, 1, 32'h500, 0, 0, 0, 0);
        cycle();
        drive(1, 1, 32'h504, 0, 0, 0, 0);
        cycle();
        chk("pre_rst_count", 64'(fb_count), 64'd2);
        rst_l = 1'b0;
        cycle();
        rst_l = 1'b1;
        chk("mid_rst_count", 64'(fb_count), 64'd0);
        chk("mid_rst_f0_val", 64'(f0_val), 64'd0);
        chk("mid_rst_overflow", 64'(fb_overflow), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/el2_ifu_fetch_buf.md
Name: el2_ifu_fetch_buf

Overview:
- Fetch buffer directly downstream of fetch control (el2_ifu_ifc_ctl).
- Captures each F-stage fetch packet that hits: 4 bytes of instruction data, PC, halfword-valid mask and access-fault flag.
- Presents the two oldest packets to the aligner; the aligner returns consume1/consume2, which also feed fetch control's mass-balance logic.
- Capacity matches the 4-slot fullness model in fetch control, so fetch control's throttling keeps this buffer from overflowing.

Parameters:
- DEPTH, 4, number of packet slots; power of two, at least 2.
- DATA_W, 32, instruction bits per packet (2 halfwords).
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  core active clock
- rst_l  input  1  synchronous active-low reset
- ifc_fetch_req_f  input  1  fetch valid in F
- ic_hit_f  input  1  I-cache/ICCM hit in F
- ifc_fetch_addr_f  input  31  F-stage fetch PC [31:1]
- ic_data_f  input  DATA_W  fetched instruction bits
- ic_access_fault_f  input  1  access fault on this fetch
- exu_flush_final  input  1  pipeline flush
- ifu_fb_consume1  input  1  aligner consumed 1 packet
- ifu_fb_consume2  input  1  aligner consumed 2 packets
- f0_val  output  2  halfword valid for oldest packet
- f0_pc  output  31  PC of oldest packet
- f0_data  output  DATA_W  data of oldest packet
- f0_err  output  1  fault of oldest packet
- f1_val, f1_pc, f1_data, f1_err  output  2/31/DATA_W/1  second-oldest packet
- fb_count  output  PTR_W+1  occupancy
- fb_overflow  output  1  sticky: write dropped while full

Behaviour:
- Write enable: wr = ifc_fetch_req_f & ic_hit_f & ~exu_flush_final.
- Halfword valid on write: ifc_fetch_addr_f[1] ? 2'b10 : 2'b01|2'b10, i.e. 2'b11 if addr[1]=0, else 2'b10 (entry halfword 0 invalid).
- Pop: pop = consume2 ? 2 : consume1 ? 1 : 0. consume2 takes priority if both are set.
- Pop saturates at fb_count; excess consume is ignored and fb_count never goes negative.
- Ordering within a cycle: pop is applied before write. A write while fb_count==DEPTH is accepted if pop>=1 the same cycle.
- Write with fb_count==DEPTH and pop==0: packet dropped, fb_overflow set (sticky until reset), pointers unchanged.
- Next count: fb_count_next = fb_count - pop_eff + wr_accepted.
- Read and write pointers are PTR_W bits and wrap modulo DEPTH.
- Flush: when exu_flush_final=1, the next cycle has fb_count=0 and both pointers=0, and all pops and writes that cycle are ignored. fb_overflow is not cleared by flush.
- Outputs are registered-state reads:
  - f0_* = entry[rd_ptr]; f0_val = 2'b00 when fb_count==0.
  - f1_* = entry[rd_ptr+1]; f1_val = 2'b00 when fb_count<2.
  - Write data is first visible on f0/f1 one cycle after write (latency 1), unless the bypass feature is enabled.
- Reset (rst_l=0 at a clk edge): fb_count=0, pointers=0, fb_overflow=0, all valid outputs 0. pc/data/err reset to 0.
- Reset mid-operation drops all contents. Data arrays need no reset beyond the valid masking.
- No internal FSM. State is pointers, count, array and sticky flag.

Optional Feature:
- Macro: EL2_FB_BYPASS_EN.
- Enabled: when fb_count==0 and wr=1, the incoming packet drives f0_* combinationally in the same cycle.
  - If consume1 or consume2 is asserted that cycle, the packet is consumed and not written; fb_count stays 0.
  - Otherwise it is written normally.
- Disabled: strict 1-cycle write-to-f0 latency; consume with fb_count==0 is ignored.

Decomposition:
- el2_pkg gains typedef el2_fb_pkt_t: val[1:0], pc[31:1], data[DATA_W-1:0], err.
- el2_pkg gains constant EL2_FB_DEPTH=4, shared with fetch control's fullness model.
- No sub-module. The storage array and pointer logic are inline, using rvdffe per entry with enable = wr_accepted & (wr_ptr==i).

Test Plan:
- Write at PCs 0x100, 0x104, 0x108 (addr[1]=0) with no consume -> fb_count=3; f0_pc=0x100 (as [31:1]=0x80), f1_pc=0x104; f0_val=f1_val=2'b11.
- Fill to 4, then write with consume1=1 the same cycle -> accepted; fb_count stays 4, f0 advances to the second packet, fb_overflow=0.
- Fill to 4, then write with no consume -> packet dropped, fb_overflow=1 and stays 1 after a later flush.
- Write at addr 0x102 (addr[1]=1) -> f0_val=2'b10. Assert consume2 with fb_count=1 -> fb_count=0, no underflow.
- With fb_count=3, assert exu_flush_final together with a hit write and consume1 -> next cycle fb_count=0, f0_val=f1_val=0.
- Wrap: 10 write/consume1 pairs with rd_ptr wrapping past 3 -> f0 PCs in order. With EL2_FB_BYPASS_EN and empty buffer, write plus consume1 -> f0 shows the packet the same cycle and fb_count remains 0.
